// File: rtl/seq_serializer.sv
// seq_serializer -- upstream stage of the serial sequence detector.
//
// Accepts a parallel word through a valid/ready handshake and shifts it out
// one bit per clock on x. A one-cycle done pulse follows the last bit of each
// frame. While hold is high in SHIFT, the current bit stays on x.
//
// Optional feature: define SEQ_SERIALIZER_PARITY_EN to append an even parity
// bit (XOR of all captured data bits) after the last data bit.
//
// Parameters:
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high
//   load_valid  load_data is valid this cycle
//   load_data   word to serialize
//   load_ready  block can accept a word (registered)
//   hold        freezes shifting while high (ignored in IDLE)
//   x           serial bit (registered)
//   x_valid     x carries a frame bit (registered)
//   done        one-cycle pulse after the final bit of a frame (registered)
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  logic             state;
  logic [CW-1:0]    count;
  logic [FRAME-1:0] sreg;
  logic [WIDTH-1:0] ordered;
  logic [FRAME-1:0] frame;

  function automatic logic [WIDTH-1:0] reverse_bits(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // The frame is always arranged so that its MSB leaves first; the shift
  // register then only ever shifts left regardless of bit order.
  always_comb begin
    ordered = (MSB_FIRST != 0) ? load_data : reverse_bits(load_data);
`ifdef SEQ_SERIALIZER_PARITY_EN
    frame = {ordered, ^load_data};
`else
    frame = ordered;
`endif
  end

  // count holds the number of bits still to come after the one on x.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      sreg       <= '0;
      x          <= 1'b0;
      x_valid    <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (load_valid) begin
        state      <= SHIFT;
        x          <= frame[FRAME-1];
        sreg       <= frame << 1;
        x_valid    <= 1'b1;
        load_ready <= 1'b0;
        count      <= LAST;
      end
    end else if (!hold) begin
      if (count != '0) begin
        x     <= sreg[FRAME-1];
        sreg  <= sreg << 1;
        count <= count - 1'b1;
      end else begin
        state      <= IDLE;
        x          <= 1'b0;
        x_valid    <= 1'b0;
        done       <= 1'b1;
        load_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Testbench for seq_serializer: one MSB-first and one LSB-first instance
// share the same stimulus; each is compared every cycle against a frame-level
// reference model, plus directed checks of bit patterns and done timing.
module tb_seq_serializer;

  localparam int WIDTH = 8;
`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             hold;
  logic             rdy0, x0, xv0, done0;
  logic             rdy1, x1, xv1, done1;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = MSB-first DUT, 1 = LSB-first DUT.
  logic m_busy [2];
  logic m_x    [2];
  logic m_xv   [2];
  logic m_done [2];
  logic m_rdy  [2];
  int   m_pos  [2];
  logic m_bits [2][0:32];

  seq_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy0), .hold(hold), .x(x0), .x_valid(xv0), .done(done0)
  );

  seq_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy1), .hold(hold), .x(x1), .x_valid(xv1), .done(done1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: a word becomes a list of bits in transmit order; each
  // unheld edge presents the next bit, and the edge after the last bit ends
  // the frame with done.
  function automatic void model_edge(input int d, input logic rst, input logic lv,
                                     input logic [WIDTH-1:0] data, input logic hd);
    if (rst) begin
      m_busy[d] = 0; m_x[d] = 0; m_xv[d] = 0; m_done[d] = 0; m_rdy[d] = 1; m_pos[d] = 0;
    end else if (!m_busy[d]) begin
      m_done[d] = 0;
      if (lv) begin
        for (int k = 0; k < WIDTH; k++)
          m_bits[d][k] = (d == 0) ? data[WIDTH-1-k] : data[k];
        m_bits[d][WIDTH] = ^data;
        m_pos[d]  = 0;
        m_busy[d] = 1;
        m_x[d]    = m_bits[d][0];
        m_xv[d]   = 1;
        m_rdy[d]  = 0;
      end
    end else if (!hd) begin
      if (m_pos[d] < FRAME - 1) begin
        m_pos[d] = m_pos[d] + 1;
        m_x[d]   = m_bits[d][m_pos[d]];
      end else begin
        m_busy[d] = 0; m_x[d] = 0; m_xv[d] = 0; m_done[d] = 1; m_rdy[d] = 1;
      end
    end
  endfunction

  task automatic cyc(input logic rst, input logic lv, input logic [WIDTH-1:0] d,
                     input logic hd);
    reset = rst; load_valid = lv; load_data = d; hold = hd;
    @(posedge clock);
    model_edge(0, rst, lv, d, hd);
    model_edge(1, rst, lv, d, hd);
    #1;
    chk("msb_x", x0, m_x[0]);
    chk("msb_x_valid", xv0, m_xv[0]);
    chk("msb_done", done0, m_done[0]);
    chk("msb_load_ready", rdy0, m_rdy[0]);
    chk("lsb_x", x1, m_x[1]);
    chk("lsb_x_valid", xv1, m_xv[1]);
    chk("lsb_done", done1, m_done[1]);
    chk("lsb_load_ready", rdy1, m_rdy[1]);
  endtask

  // Loads a word and collects the frame bits seen on both DUTs (first bit in
  // the highest collected position) and the edges from load to done.
  task automatic run_frame(input logic [WIDTH-1:0] data, output logic [32:0] cap0,
                           output logic [32:0] cap1, output int n);
    cyc(0, 1, data, 0);
    cap0 = {32'd0, x0};
    cap1 = {32'd0, x1};
    n = 0;
    while (!done0 && n < 40) begin
      cyc(0, 0, '0, 0);
      n++;
      if (xv0) cap0 = {cap0[31:0], x0};
      if (xv1) cap1 = {cap1[31:0], x1};
    end
    chk("frame_done_seen", done0, 1'b1);
  endtask

  logic [32:0] c0, c1, e0, e1;
  int          n;
  logic [7:0]  pat;

  initial begin
    reset = 1; load_valid = 0; load_data = '0; hold = 0;

    // Reset state
    cyc(1, 0, '0, 0);
    cyc(1, 1, 8'h55, 1);
    chk("reset_ready", rdy0, 1'b1);
    chk("reset_x_valid", xv0, 1'b0);
    cyc(0, 0, '0, 0);

    // Test 1 + 2: bit order on both instances, done timing
    pat = 8'b11100111;
    cyc(0, 1, pat, 0);
    for (int k = 0; k < WIDTH; k++) begin
      chk("t1_bit", x0, pat[WIDTH-1-k]);
      chk("t1_busy_ready", rdy0, 1'b0);
      cyc(0, 0, '0, 0);
    end
`ifdef SEQ_SERIALIZER_PARITY_EN
    chk("t6_parity_e7", x0, 1'b0);
    chk("t6_parity_valid", xv0, 1'b1);
    cyc(0, 0, '0, 0);
`endif
    chk("t1_done", done0, 1'b1);
    chk("t1_end_x_valid", xv0, 1'b0);
    cyc(0, 0, '0, 0);
    chk("t1_done_pulse_width", done0, 1'b0);

    run_frame(8'h0F, c0, c1, n);
`ifdef SEQ_SERIALIZER_PARITY_EN
    e0 = 33'h01E; e1 = 33'h1E0;
`else
    e0 = 33'h0F; e1 = 33'hF0;
`endif
    chk("t2_msb_bits", c0, e0);
    chk("t2_lsb_bits", c1, e1);
    chk("t2_done_cycle", n, FRAME);
    cyc(0, 0, '0, 0);

    // Test 3: hold for 3 edges while the third bit is on x
    cyc(0, 1, 8'b10110000, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    n = 2;
    for (int k = 0; k < 3; k++) begin
      chk("t3_held_bit", x0, 1'b1);
      cyc(0, 0, '0, 1);
      n++;
    end
    chk("t3_held_bit_last", x0, 1'b1);
    chk("t3_held_valid", xv0, 1'b1);
    while (!done0 && n < 40) begin
      cyc(0, 0, '0, 0);
      n++;
    end
    chk("t3_done_cycle", n, FRAME + 3);

    // Test 4: load during busy is ignored; back-to-back from the done cycle
    cyc(0, 1, 8'h3C, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 1, 8'hFF, 0);
    chk("t4_busy_ignored_x", x0, 1'b1);
    n = 0;
    while (!done0 && n < 40) begin
      cyc(0, 0, '0, 0);
      n++;
    end
    run_frame(8'h81, c0, c1, n);
`ifdef SEQ_SERIALIZER_PARITY_EN
    e0 = 33'h102;
`else
    e0 = 33'h81;
`endif
    chk("t4_b2b_first", c0, e0);
    run_frame(8'h81, c0, c1, n);
    chk("t4_b2b_second", c0, e0);
    chk("t4_b2b_done_cycle", n, FRAME);

    // Test 5: reset mid-frame
    cyc(0, 1, 8'hAA, 0);
    cyc(0, 0, '0, 0);
    cyc(1, 0, '0, 0);
    chk("t5_abort_x", x0, 1'b0);
    chk("t5_abort_ready", rdy0, 1'b1);
    for (int k = 0; k < 12; k++) cyc(0, 0, '0, 0);
    run_frame(8'h96, c0, c1, n);
    chk("t5_fresh_done_cycle", n, FRAME);

`ifdef SEQ_SERIALIZER_PARITY_EN
    // Test 6: parity bit values
    run_frame(8'b11100111, c0, c1, n);
    chk("t6_frame_e7", c0, 33'h1CE);
    chk("t6_done_cycle", n, FRAME);
    run_frame(8'h07, c0, c1, n);
    chk("t6_parity_07", c0[0], 1'b1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
          WIDTH'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Upstream stage of the serial sequence detector.
- Accepts a parallel word through a valid/ready handshake and shifts it out one bit per clock on x, which the detector samples every rising edge.
- Produces a one-cycle done pulse after the last bit of each word; supports stalling through hold.

Parameters:
WIDTH, 8, number of data bits per word (legal range 2..32)
MSB_FIRST, 1, 1 = bit WIDTH-1 leaves first; 0 = bit 0 leaves first

Ports:
clock  input  1  single rising-edge clock for all state
reset  input  1  synchronous, active-high; clears all state on the rising edge of clock while high
load_valid  input  1  load_data is valid this cycle
load_data  input  WIDTH  word to serialize
load_ready  output  1  block can accept a word this cycle
hold  input  1  freezes shifting while high
x  output  1  serial bit to the sequence detector
x_valid  output  1  x carries a frame bit this cycle
done  output  1  one-cycle pulse after the final bit of a frame

Behaviour:
- All outputs are registered. Reset values: x=0, x_valid=0, done=0, load_ready=1. Internal state after reset: FSM in IDLE, bit counter 0, shift register 0.
- Reset wins over every other input in the same cycle. Reset mid-frame aborts the word: no done pulse, x=0 from the next cycle.
- FSM states:
  - IDLE: load_ready=1, x_valid=0, x=0.
  - SHIFT: load_ready=0, x_valid=1.
- Accept: on an edge with state=IDLE and load_valid=1, the block captures load_data, moves to SHIFT, sets x to the first bit and x_valid=1, and loads counter=FRAME-1.
  - FRAME = WIDTH, or WIDTH+1 with the optional feature.
- SHIFT, with hold=0 at the edge:
  - If counter>0: x takes the next bit in order, counter decrements.
  - If counter=0: return to IDLE, x=0, x_valid=0, done=1 for exactly one cycle, load_ready=1.
- SHIFT, with hold=1 at the edge: x, x_valid, counter and shift register are unchanged. The current bit is presented for as long as hold stays high.
- hold is ignored in IDLE and does not block acceptance.
- load_valid while load_ready=0 is ignored; the word is not queued.
- Timing without hold, word accepted at edge N:
  - Bit k is on x during cycle N+1+k.
  - done is high during cycle N+FRAME+1.
- A new word may be accepted at the edge that ends the done cycle. Consecutive frames are therefore separated by exactly one idle cycle, with x=0 and x_valid=0.
- The counter is ceil(log2(WIDTH+1)) bits wide and never wraps below 0.

Optional Feature:
- Macro: SEQ_SERIALIZER_PARITY_EN.
- Defined:
  - FRAME=WIDTH+1.
  - After the last data bit, one extra cycle carries the even parity bit (XOR of all captured data bits) with x_valid=1.
  - hold applies to the parity bit as well.
  - done follows the parity bit.
- Undefined:
  - FRAME=WIDTH; no parity logic is present.
  - done directly follows the last data bit.

Test Plan:
1. Bit order, MSB_FIRST=1, WIDTH=8, no parity. Release reset, then load_data=8'b11100111 with load_valid=1 for one edge (N). Required: x=1,1,1,0,0,1,1,1 in cycles N+1..N+8 with x_valid=1; cycle N+9 has x=0, x_valid=0, done=1; load_ready=0 in N+1..N+8.
2. LSB-first order, MSB_FIRST=0. Load 8'h0F. Required: x=1,1,1,1,0,0,0,0; done in cycle N+9.
3. Hold stall. Load 8'b10110000 with MSB_FIRST=1; assert hold for 3 cycles while the third bit (1) is presented. Required: x stays 1 with x_valid=1 for 4 cycles total; the remaining bits follow unchanged; done moves to cycle N+12.
4. Busy and back-to-back.
   - Pulse load_valid with 8'hFF at cycle N+4 of a frame: required ignored, no change to x.
   - Load 8'h81 during the done cycle, then 8'h81 again: required one idle cycle, then 1,0,0,0,0,0,0,1.
5. Reset mid-frame. Assert reset at cycle N+3 of 8'hAA. Required: the next cycle has x=0, x_valid=0, done=0, load_ready=1; no done pulse ever appears for that word; a fresh load then works.
6. Parity, SEQ_SERIALIZER_PARITY_EN defined, MSB_FIRST=1.
   - 8'b11100111 (six ones): 9th bit=0, done in cycle N+10.
   - 8'h07: 9th bit=1.
